// File: rtl/csc_pkg.sv
// Shared definitions for the multi-standard colour space converter:
// mode encoding, coefficient tables and pipeline constants.
package csc_pkg;

   localparam int FRAC = 8;
   localparam int LAT  = 4;
   localparam int CW   = 10;

   typedef enum logic [1:0] {
      MODE_601    = 2'd0,
      MODE_709    = 2'd1,
      MODE_YCC601 = 2'd2,
      MODE_BYPASS = 2'd3
   } mode_e;

   typedef logic signed [CW-1:0] coef_t;
   typedef coef_t [2:0]          coef_row_t;
   typedef coef_row_t [2:0]      coef_mat_t;   // [output channel][input component]

   function automatic coef_row_t mk_row(input coef_t a, input coef_t b, input coef_t c);
      coef_row_t r;
      r[0] = a;
      r[1] = b;
      r[2] = c;
      return r;
   endfunction

   // Bypass reuses the datapath with an identity matrix so it stays bit-exact.
   function automatic coef_mat_t coef_lookup(input mode_e m);
      coef_mat_t c;
      case (m)
         MODE_601: begin
            c[0] = mk_row( 10'sd77,   10'sd150,  10'sd29);
            c[1] = mk_row(-10'sd43,  -10'sd85,   10'sd128);
            c[2] = mk_row( 10'sd128, -10'sd107, -10'sd21);
         end
         MODE_709: begin
            c[0] = mk_row( 10'sd54,   10'sd183,  10'sd18);
            c[1] = mk_row(-10'sd29,  -10'sd99,   10'sd128);
            c[2] = mk_row( 10'sd128, -10'sd116, -10'sd12);
         end
         MODE_YCC601: begin
            c[0] = mk_row( 10'sd256,  10'sd0,    10'sd359);
            c[1] = mk_row( 10'sd256, -10'sd88,  -10'sd183);
            c[2] = mk_row( 10'sd256,  10'sd454,  10'sd0);
         end
         default: begin
            c[0] = mk_row( 10'sd256,  10'sd0,    10'sd0);
            c[1] = mk_row( 10'sd0,    10'sd256,  10'sd0);
            c[2] = mk_row( 10'sd0,    10'sd0,    10'sd256);
         end
      endcase
      return c;
   endfunction

endpackage

// File: rtl/csc_if.sv
// Video stream bundle for csc_multi: input pixel/syncs/mode request and
// the delayed, converted output stream.
interface csc_if #(parameter int DW = 8);

   logic            in_hsync;
   logic            in_vsync;
   logic            in_de;
   logic [3*DW-1:0] in_data;
   logic [1:0]      mode_sel;
   logic            out_hsync;
   logic            out_vsync;
   logic            out_de;
   logic [3*DW-1:0] out_data;
   logic [1:0]      mode_act;

   modport master (
      output in_hsync, in_vsync, in_de, in_data, mode_sel,
      input  out_hsync, out_vsync, out_de, out_data, mode_act
   );

   modport slave (
      input  in_hsync, in_vsync, in_de, in_data, mode_sel,
      output out_hsync, out_vsync, out_de, out_data, mode_act
   );

endinterface

// File: rtl/csc_mac3.sv
// One output channel: three signed products (S2), sum plus bias and
// rounding (S3), shift/clip into the output register (S4).
module csc_mac3
   import csc_pkg::*;
#(
   parameter int DW = 8
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 i_de,
   input  logic signed [DW:0]   i_x0,
   input  logic signed [DW:0]   i_x1,
   input  logic signed [DW:0]   i_x2,
   input  coef_t                i_c0,
   input  coef_t                i_c1,
   input  coef_t                i_c2,
   input  logic signed [DW+10:0] i_bias,
   output logic [DW-1:0]        o_y
);

   localparam int AW = DW + 11;
   localparam logic signed [AW-1:0] RND  = {{(AW-FRAC){1'b0}}, 1'b1, {(FRAC-1){1'b0}}};
   localparam logic signed [AW-1:0] MAXV = {{(AW-DW){1'b0}}, {DW{1'b1}}};

   logic signed [AW-1:0] r_p0;
   logic signed [AW-1:0] r_p1;
   logic signed [AW-1:0] r_p2;
   logic signed [AW-1:0] r_bias;
   logic signed [AW-1:0] r_acc;
   logic        [DW-1:0] r_y;
   logic signed [AW-1:0] w_sh;
   logic        [DW-1:0] w_clip;

   // S2/S3: products, then sum with bias and half-LSB rounding
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_p0   <= '0;
         r_p1   <= '0;
         r_p2   <= '0;
         r_bias <= '0;
         r_acc  <= '0;
      end else begin
         r_p0   <= AW'(i_x0) * AW'(i_c0);
         r_p1   <= AW'(i_x1) * AW'(i_c1);
         r_p2   <= AW'(i_x2) * AW'(i_c2);
         r_bias <= i_bias;
         r_acc  <= r_p0 + r_p1 + r_p2 + r_bias + RND;
      end
   end

   always_comb begin
      w_sh = r_acc >>> FRAC;
      if (w_sh[AW-1]) begin
         w_clip = {DW{1'b0}};
      end else if (w_sh > MAXV) begin
         w_clip = {DW{1'b1}};
      end else begin
         w_clip = w_sh[DW-1:0];
      end
   end

   // S4: blanking forces the channel to zero
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_y <= '0;
      end else if (!i_de) begin
         r_y <= '0;
      end else begin
         r_y <= w_clip;
      end
   end

   assign o_y = r_y;

endmodule

// File: rtl/csc_multi.sv
// Multi-standard colour space converter with a fixed 4-cycle pipeline;
// the conversion mode only changes on a rising edge of in_vsync.
module csc_multi
   import csc_pkg::*;
#(
   parameter int DW = 8
) (
   input logic clk,
   input logic rst,
   csc_if.slave bus
);

   localparam int LAT = csc_pkg::LAT;
   localparam int AW  = DW + 11;
   localparam logic signed [DW:0]   OFS    = {2'b01, {(DW-1){1'b0}}};
   localparam logic signed [AW-1:0] BIAS_C = {{(AW-DW-FRAC){1'b0}}, 1'b1, {(DW-1+FRAC){1'b0}}};

   logic                 r_vs_prev;
   mode_e                r_mode_act;
   logic signed [DW:0]   r_x0;
   logic signed [DW:0]   r_x1;
   logic signed [DW:0]   r_x2;
   coef_mat_t            r_cf;
   logic signed [AW-1:0] r_bias_c;
   logic [LAT-1:0]       r_de;
   logic [LAT-1:0]       r_hs;
   logic [LAT-1:0]       r_vs;

   logic [DW-1:0]        w_c0;
   logic [DW-1:0]        w_c1;
   logic [DW-1:0]        w_c2;
   logic                 w_vs_rise;
   mode_e                w_mode_nxt;
   logic signed [DW:0]   w_x0;
   logic signed [DW:0]   w_x1;
   logic signed [DW:0]   w_x2;
   logic signed [AW-1:0] w_bias_c;
   logic [DW-1:0]        w_y0;
   logic [DW-1:0]        w_y1;
   logic [DW-1:0]        w_y2;

   assign w_c0 = bus.in_data[3*DW-1:2*DW];
   assign w_c1 = bus.in_data[2*DW-1:DW];
   assign w_c2 = bus.in_data[DW-1:0];

   // A pixel arriving with the vsync edge already uses the newly loaded mode.
   always_comb begin
      w_vs_rise = bus.in_vsync & ~r_vs_prev;
      if (w_vs_rise) begin
         w_mode_nxt = mode_e'(bus.mode_sel);
      end else begin
         w_mode_nxt = r_mode_act;
      end
      w_x0 = $signed({1'b0, w_c0});
      if (w_mode_nxt == MODE_YCC601) begin
         w_x1 = $signed({1'b0, w_c1}) - OFS;
         w_x2 = $signed({1'b0, w_c2}) - OFS;
      end else begin
         w_x1 = $signed({1'b0, w_c1});
         w_x2 = $signed({1'b0, w_c2});
      end
      case (w_mode_nxt)
         MODE_601, MODE_709: w_bias_c = BIAS_C;
         default:            w_bias_c = {AW{1'b0}};
      endcase
   end

   // S1: mode tracking, input/offset registers, per-pixel coefficients, sync delay lines
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_vs_prev  <= 1'b0;
         r_mode_act <= MODE_601;
         r_x0       <= '0;
         r_x1       <= '0;
         r_x2       <= '0;
         r_cf       <= '0;
         r_bias_c   <= '0;
         r_de       <= '0;
         r_hs       <= '0;
         r_vs       <= '0;
      end else begin
         r_vs_prev  <= bus.in_vsync;
         r_mode_act <= w_mode_nxt;
         r_x0       <= w_x0;
         r_x1       <= w_x1;
         r_x2       <= w_x2;
         r_cf       <= coef_lookup(w_mode_nxt);
         r_bias_c   <= w_bias_c;
         r_de       <= {r_de[LAT-2:0], bus.in_de};
         r_hs       <= {r_hs[LAT-2:0], bus.in_hsync};
         r_vs       <= {r_vs[LAT-2:0], bus.in_vsync};
      end
   end

   csc_mac3 #(.DW(DW)) u_mac0 (
      .clk(clk), .rst(rst), .i_de(r_de[LAT-2]),
      .i_x0(r_x0), .i_x1(r_x1), .i_x2(r_x2),
      .i_c0(r_cf[0][0]), .i_c1(r_cf[0][1]), .i_c2(r_cf[0][2]),
      .i_bias({AW{1'b0}}), .o_y(w_y0)
   );

   csc_mac3 #(.DW(DW)) u_mac1 (
      .clk(clk), .rst(rst), .i_de(r_de[LAT-2]),
      .i_x0(r_x0), .i_x1(r_x1), .i_x2(r_x2),
      .i_c0(r_cf[1][0]), .i_c1(r_cf[1][1]), .i_c2(r_cf[1][2]),
      .i_bias(r_bias_c), .o_y(w_y1)
   );

   csc_mac3 #(.DW(DW)) u_mac2 (
      .clk(clk), .rst(rst), .i_de(r_de[LAT-2]),
      .i_x0(r_x0), .i_x1(r_x1), .i_x2(r_x2),
      .i_c0(r_cf[2][0]), .i_c1(r_cf[2][1]), .i_c2(r_cf[2][2]),
      .i_bias(r_bias_c), .o_y(w_y2)
   );

   assign bus.out_de    = r_de[LAT-1];
   assign bus.out_hsync = r_hs[LAT-1];
   assign bus.out_vsync = r_vs[LAT-1];
   assign bus.out_data  = {w_y0, w_y1, w_y2};
   assign bus.mode_act  = r_mode_act;

endmodule

// File: tb/tb_csc_multi.sv
// Directed bench for csc_multi: an integer reference model fills a
// scoreboard queue that is checked against the output LAT cycles later.
module tb_csc_multi;

   import csc_pkg::*;

   localparam int TDW = 8;

   logic clk = 1'b0;
   logic rst = 1'b1;

   csc_if #(.DW(TDW)) bus();

   csc_multi #(.DW(TDW)) dut (
      .clk(clk),
      .rst(rst),
      .bus(bus)
   );

   always #5 clk = ~clk;

   int          checks   = 0;
   int          failures = 0;
   logic [26:0] sb[$];
   logic [1:0]  m_mode_act = 2'd0;
   logic        m_vs_prev  = 1'b0;
   string       tag = "init";

   function automatic logic [7:0] rclip(input int acc);
      int v;
      v = (acc + 128) >>> 8;
      if (v < 0) return 8'd0;
      if (v > 255) return 8'd255;
      return 8'(v);
   endfunction

   function automatic logic [23:0] model(input logic [1:0] m, input logic [23:0] d);
      int a, b, c;
      a = int'(d[23:16]);
      b = int'(d[15:8]);
      c = int'(d[7:0]);
      case (m)
         2'd0: return {rclip(77*a + 150*b + 29*c),
                       rclip(-43*a - 85*b + 128*c + 32768),
                       rclip(128*a - 107*b - 21*c + 32768)};
         2'd1: return {rclip(54*a + 183*b + 18*c),
                       rclip(-29*a - 99*b + 128*c + 32768),
                       rclip(128*a - 116*b - 12*c + 32768)};
         2'd2: return {rclip(256*a + 359*(c-128)),
                       rclip(256*a - 88*(b-128) - 183*(c-128)),
                       rclip(256*a + 454*(b-128))};
         default: return d;
      endcase
   endfunction

   task automatic step(input logic de, input logic hs, input logic vs,
                       input logic [1:0] sel, input logic [23:0] d);
      logic [1:0]  old_mode;
      logic [26:0] exp_o;
      logic [26:0] obs_o;
      @(posedge clk);
      #1;
      bus.in_de    = de;
      bus.in_hsync = hs;
      bus.in_vsync = vs;
      bus.mode_sel = sel;
      bus.in_data  = d;
      old_mode = m_mode_act;
      if (vs && !m_vs_prev) m_mode_act = sel;
      m_vs_prev = vs;
      sb.push_back({de, hs, vs, de ? model(m_mode_act, d) : 24'd0});
      @(negedge clk);
      if (sb.size() > LAT) begin
         exp_o = sb.pop_front();
         obs_o = {bus.out_de, bus.out_hsync, bus.out_vsync, bus.out_data};
         checks++;
         assert (obs_o === exp_o) else begin
            failures++;
            $error("FAIL %s out{de,hs,vs,data} observed=%h expected=%h", tag, obs_o, exp_o);
         end
      end
      checks++;
      assert (bus.mode_act === old_mode) else begin
         failures++;
         $error("FAIL %s mode_act observed=%0d expected=%0d", tag, bus.mode_act, old_mode);
      end
   endtask

   task automatic do_reset();
      logic [28:0] obs_r;
      @(posedge clk);
      #2;
      rst          = 1'b1;
      bus.in_de    = 1'b0;
      bus.in_hsync = 1'b0;
      bus.in_vsync = 1'b0;
      bus.mode_sel = 2'd0;
      bus.in_data  = 24'd0;
      #1;
      obs_r = {bus.out_de, bus.out_hsync, bus.out_vsync, bus.out_data, bus.mode_act};
      checks++;
      assert (obs_r === 29'd0) else begin
         failures++;
         $error("FAIL %s reset_outputs observed=%h expected=%h", tag, obs_r, 29'd0);
      end
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      sb.delete();
      repeat (LAT) sb.push_back(27'd0);
      m_mode_act = 2'd0;
      m_vs_prev  = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      logic [23:0] rd;
      logic        rde;
      logic        rhs;
      logic        rvs;
      bus.in_de    = 1'b0;
      bus.in_hsync = 1'b0;
      bus.in_vsync = 1'b0;
      bus.mode_sel = 2'd0;
      bus.in_data  = 24'd0;

      tag = "reset_state";
      do_reset();
      repeat (3) step(1'b0, 1'b0, 1'b0, 2'd0, 24'd0);

      tag = "m0_frame_start";
      step(1'b0, 1'b0, 1'b1, 2'd0, 24'd0);
      step(1'b0, 1'b0, 1'b1, 2'd0, 24'd0);
      step(1'b0, 1'b1, 1'b0, 2'd0, 24'd0);
      tag = "m0_white";
      step(1'b1, 1'b0, 1'b0, 2'd0, 24'hFFFFFF);
      tag = "m0_red_cr_clip";
      step(1'b1, 1'b0, 1'b0, 2'd0, 24'hFF0000);
      tag = "m0_mix";
      step(1'b1, 1'b0, 1'b0, 2'd0, 24'h123456);
      step(1'b1, 1'b0, 1'b0, 2'd0, 24'h00FF80);
      step(1'b0, 1'b1, 1'b0, 2'd0, 24'd0);

      tag = "sel_change_midframe";
      for (int i = 0; i < 6; i++) begin
         rd = 24'($urandom);
         step(1'b1, 1'b0, 1'b0, 2'd1, rd);
      end
      tag = "m1_vsync_edge";
      step(1'b0, 1'b0, 1'b1, 2'd1, 24'd0);
      tag = "sel_change_vsync_high";
      step(1'b0, 1'b0, 1'b1, 2'd3, 24'd0);
      tag = "m1_red";
      step(1'b1, 1'b0, 1'b0, 2'd3, 24'hFF0000);
      step(1'b1, 1'b0, 1'b0, 2'd1, 24'h80FF40);
      step(1'b1, 1'b0, 1'b0, 2'd1, 24'hFFFFFF);

      tag = "m2_b_clip";
      step(1'b0, 1'b0, 1'b1, 2'd2, 24'd0);
      step(1'b0, 1'b0, 1'b0, 2'd2, 24'd0);
      step(1'b1, 1'b0, 1'b0, 2'd2, 24'h000080);
      tag = "m2_mix";
      step(1'b1, 1'b0, 1'b0, 2'd2, 24'hEB8080);
      step(1'b1, 1'b0, 1'b0, 2'd2, 24'h10F010);
      for (int i = 0; i < 4; i++) begin
         rd = 24'($urandom);
         step(1'b1, 1'b0, 1'b0, 2'd2, rd);
      end

      tag = "m3_bypass_stream";
      step(1'b0, 1'b0, 1'b1, 2'd3, 24'd0);
      for (int i = 0; i < 40; i++) begin
         rd  = 24'($urandom);
         rde = ($urandom_range(0, 3) != 0);
         rhs = 1'($urandom_range(0, 1));
         rvs = 1'($urandom_range(0, 1));
         step(rde, rhs, rvs, 2'd3, rd);
      end

      tag = "rst_midline";
      for (int i = 0; i < 4; i++) begin
         rd = 24'($urandom) | 24'h010101;
         step(1'b1, 1'b1, 1'b0, 2'd3, rd);
      end
      do_reset();
      tag = "post_rst_latency";
      step(1'b1, 1'b0, 1'b0, 2'd2, 24'hFFFFFF);
      step(1'b1, 1'b0, 1'b0, 2'd2, 24'hFF0000);
      tag = "drain";
      repeat (LAT + 1) step(1'b0, 1'b0, 1'b0, 2'd0, 24'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
